cp0_reg_unit: RTL
=================

// Module: cp0_reg_unit
// PURPOSE
//  MIPS32 coprocessor-0 register file; sink of the WB-stage CP0 write channel (we/addr/data from the MEM/WB register).
//  Holds Count/Compare/Status/Cause/EPC/PRId/Config and raises the timer interrupt.
//  Records exception state from the MEM-stage exception bus.
//  Serves the combinational CP0 read port used by EX (mfc0) and the exception/ctrl logic.
// PARAMETERS
//  DATA_W      32            CP0 register width
//  PRID_VAL    32'h004c0102  PRId constant
//  CONFIG_VAL  32'h00008000  Config constant (BE=1)
// PORTS
//  clk                  in   1       clock
//  rst                  in   1       reset: synchronous, active-high
//  we_i                 in   1       CP0 write enable from MEM/WB
//  waddr_i              in   5       CP0 write register number
//  data_i               in   DATA_W  CP0 write data
//  raddr_i              in   5       CP0 read register number
//  int_i                in   6       external hardware interrupts, level
//  excepttype_i         in   32      exception code from MEM (0 = none)
//  current_inst_addr_i  in   32      PC of the excepting instruction
//  is_in_delayslot_i    in   1       excepting instruction is in a delay slot
//  data_o               out  DATA_W  read data for raddr_i, combinational
//  count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  DATA_W  live register copies
//  timer_int_o          out  1       timer interrupt, registered
// BEHAVIOUR
//  Register numbers: Count=9, Compare=11, Status=12, Cause=13, EPC=14, PRId=15, Config=16.
//  Reset values:
//   - count/compare/cause/epc/timer_int_o = 0
//   - status = 32'h10000000 (CU0=1)
//   - config = CONFIG_VAL; prid = PRID_VAL
//  Per cycle, not in reset:
//   - count <= count+1; wraps 32'hFFFFFFFF -> 0
//   - cause[15:10] <= int_i (1-cycle sampling latency)
//  Timer interrupt:
//   - compare != 0 and count == compare sets timer_int_o=1 the next cycle; it then holds
//   - Any Compare write clears timer_int_o next cycle; the Compare write wins over a same-cycle match
//  Writes (we_i=1), effective next edge:
//   - Count: replaces the increment
//   - Compare: full word
//   - Status: full word
//   - EPC: full word
//   - Cause: only IP[1:0]=bits[9:8], WP=bit22, IV=bit23; other bits keep value
//   - PRId, Config, unknown numbers: write ignored
//  Exceptions, same edge. Exception updates override a same-cycle WB write to the same field.
//   - excepttype 32'h1 (int), ExcCode 0
//   - 32'h8 (syscall), ExcCode 8
//   - 32'ha (RI), ExcCode 10
//   - 32'hd (trap), ExcCode 13
//   - 32'hc (overflow), ExcCode 12
//  Exception updates, for the codes above:
//   - If status.EXL==0: EPC <= is_in_delayslot_i ? pc-4 : pc; cause.BD <= is_in_delayslot_i
//   - If status.EXL==1: EPC and BD unchanged
//   - status.EXL <= 1; cause[6:2] <= ExcCode
//  Other excepttype values:
//   - 32'he (eret): status.EXL <= 0; nothing else
//   - Any other nonzero code: no CP0 update
//  Read port: data_o = register selected by raddr_i; 0 for unknown numbers; no clock latency.
//  rst asserted mid-operation: all state returns to reset values at that edge, including a pending timer interrupt.
// CONFIGURATION
//  CP0_WB_BYPASS_EN defined:
//   - data_o forwards data_i when we_i && waddr_i==raddr_i
//   - Forwarded value uses the same field masking rules; Cause shows merged writable bits
//   - Forwarding applies to writable registers only
//  CP0_WB_BYPASS_EN undefined:
//   - data_o shows the registered value; a new write is visible the cycle after the write
// TESTING
//  1. rst 1 cycle -> status=32'h10000000, prid=PRID_VAL, count=0; count=5 after 5 free cycles
//  2. Write Compare=20 and Count=10 -> timer_int_o=1 exactly 11 cycles after the Count write edge; Compare write clears it next cycle
//  3. excepttype=32'h8, pc=32'h100, delayslot=1 with EXL=0 -> epc=32'hFC, cause.BD=1, ExcCode=8, EXL=1; then 32'he -> EXL=0
//  4. Second exception while EXL=1 -> epc unchanged, ExcCode updated
//  5. Write Cause=32'hFFFFFFFF -> only bits 23,22,9,8 set; PRId write ignored
//  6. we_i=1, waddr=raddr=14, data=32'hABC -> data_o=32'hABC same cycle with CP0_WB_BYPASS_EN, old EPC without it

Source files
------------

// File: rtl/cp0_reg_unit_if.sv
// Groups the CP0 register-file write and read ports.
// The WB stage drives the write channel; EX/ctrl drives raddr_i and reads data_o.
interface cp0_reg_unit_if #(
  parameter int DATA_W = 32
);
  logic              we_i;
  logic [4:0]        waddr_i;
  logic [DATA_W-1:0] data_i;
  logic [4:0]        raddr_i;
  logic [DATA_W-1:0] data_o;

  modport master (output we_i, output waddr_i, output data_i, output raddr_i, input data_o);
  modport slave  (input we_i, input waddr_i, input data_i, input raddr_i, output data_o);
endinterface

// File: rtl/cp0_reg_unit.sv
// MIPS32 CP0 register file: Count/Compare/Status/Cause/EPC/PRId/Config, timer interrupt, exception capture.
// Optional build macro CP0_WB_BYPASS_EN forwards a same-cycle WB write onto the read port.
module cp0_reg_unit #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] PRID_VAL   = DATA_W'(32'h004c0102),
  parameter logic [DATA_W-1:0] CONFIG_VAL = DATA_W'(32'h00008000)
) (
  input  logic              clk,
  input  logic              rst,
  cp0_reg_unit_if.slave     bus,
  input  logic [5:0]        int_i,
  input  logic [31:0]       excepttype_i,
  input  logic [31:0]       current_inst_addr_i,
  input  logic              is_in_delayslot_i,
  output logic [DATA_W-1:0] count_o,
  output logic [DATA_W-1:0] compare_o,
  output logic [DATA_W-1:0] status_o,
  output logic [DATA_W-1:0] cause_o,
  output logic [DATA_W-1:0] epc_o,
  output logic [DATA_W-1:0] config_o,
  output logic [DATA_W-1:0] prid_o,
  output logic              timer_int_o
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;
  localparam logic [4:0] REG_CONFIG  = 5'd16;

  // Software-writable Cause bits: IV, WP, IP[1:0]
  localparam logic [DATA_W-1:0] CAUSE_WMASK  = DATA_W'(32'h00C00300);
  localparam logic [DATA_W-1:0] STATUS_RESET = DATA_W'(32'h10000000);

  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] compare_q, compare_d;
  logic [DATA_W-1:0] status_q, status_d;
  logic [DATA_W-1:0] cause_q, cause_d;
  logic [DATA_W-1:0] epc_q, epc_d;
  logic              timer_int_q, timer_int_d;

  logic              wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic              exc_hit, exc_eret;
  logic [4:0]        exc_code;
  logic [DATA_W-1:0] cause_wmerge;

  always_comb begin
    wr_count   = bus.we_i && (bus.waddr_i == REG_COUNT);
    wr_compare = bus.we_i && (bus.waddr_i == REG_COMPARE);
    wr_status  = bus.we_i && (bus.waddr_i == REG_STATUS);
    wr_cause   = bus.we_i && (bus.waddr_i == REG_CAUSE);
    wr_epc     = bus.we_i && (bus.waddr_i == REG_EPC);
    cause_wmerge = (cause_q & ~CAUSE_WMASK) | (bus.data_i & CAUSE_WMASK);
  end

  always_comb begin
    exc_hit  = 1'b0;
    exc_eret = 1'b0;
    exc_code = 5'd0;
    case (excepttype_i)
      32'h0000_0001: begin exc_hit = 1'b1; exc_code = 5'd0;  end
      32'h0000_0008: begin exc_hit = 1'b1; exc_code = 5'd8;  end
      32'h0000_000a: begin exc_hit = 1'b1; exc_code = 5'd10; end
      32'h0000_000d: begin exc_hit = 1'b1; exc_code = 5'd13; end
      32'h0000_000c: begin exc_hit = 1'b1; exc_code = 5'd12; end
      32'h0000_000e: exc_eret = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    count_d     = wr_count ? bus.data_i : count_q + 1'b1;
    compare_d   = wr_compare ? bus.data_i : compare_q;
    status_d    = wr_status ? bus.data_i : status_q;
    epc_d       = wr_epc ? bus.data_i : epc_q;
    cause_d     = wr_cause ? cause_wmerge : cause_q;
    cause_d[15:10] = int_i;

    timer_int_d = timer_int_q;
    if ((compare_q != '0) && (count_q == compare_q))
      timer_int_d = 1'b1;
    if (wr_compare)
      timer_int_d = 1'b0;

    // Exception capture is applied last so it overrides any WB write to the same field
    if (exc_hit) begin
      if (!status_q[1]) begin
        epc_d       = is_in_delayslot_i ? DATA_W'(current_inst_addr_i - 32'd4)
                                        : DATA_W'(current_inst_addr_i);
        cause_d[31] = is_in_delayslot_i;
      end
      status_d[1]  = 1'b1;
      cause_d[6:2] = exc_code;
    end else if (exc_eret) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      compare_q   <= '0;
      status_q    <= STATUS_RESET;
      cause_q     <= '0;
      epc_q       <= '0;
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      timer_int_q <= timer_int_d;
    end
  end

  always_comb begin
    case (bus.raddr_i)
      REG_COUNT:   bus.data_o = count_q;
      REG_COMPARE: bus.data_o = compare_q;
      REG_STATUS:  bus.data_o = status_q;
      REG_CAUSE:   bus.data_o = cause_q;
      REG_EPC:     bus.data_o = epc_q;
      REG_PRID:    bus.data_o = PRID_VAL;
      REG_CONFIG:  bus.data_o = CONFIG_VAL;
      default:     bus.data_o = '0;
    endcase
`ifdef CP0_WB_BYPASS_EN
    if (bus.we_i && (bus.waddr_i == bus.raddr_i)) begin
      case (bus.raddr_i)
        REG_COUNT, REG_COMPARE, REG_STATUS, REG_EPC: bus.data_o = bus.data_i;
        REG_CAUSE:                                   bus.data_o = cause_wmerge;
        default: ;
      endcase
    end
`endif
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign config_o    = CONFIG_VAL;
  assign prid_o      = PRID_VAL;
  assign timer_int_o = timer_int_q;

endmodule
